// File: rtl/llc_mem_bridge_if.sv
// LLC-side request/response bundles carried by the memory bridge.
// The LLC drives llc_mem_req_t and consumes llc_mem_rsp_t.
interface llc_mem_req_t #(
    parameter int LINE_ADDR_BITS = 28,
    parameter int LINE_BITS      = 128
);
    logic                      hwrite;
    logic [2:0]                hsize;
    logic [1:0]                hprot;
    logic [LINE_ADDR_BITS-1:0] addr;
    logic [LINE_BITS-1:0]      line;

    modport in  (input  hwrite, hsize, hprot, addr, line);
    modport out (output hwrite, hsize, hprot, addr, line);
endinterface

interface llc_mem_rsp_t #(
    parameter int LINE_BITS = 128
);
    logic [LINE_BITS-1:0] line;

    modport in  (input  line);
    modport out (output line);
endinterface

// File: rtl/llc_mem_bridge.sv
// Serializes one LLC line request into word beats on the memory port and,
// for reads, reassembles the returned words into a line for the LLC.
module llc_mem_bridge #(
    parameter int ADDR_BITS      = 32,
    parameter int BITS_PER_WORD  = 64,
    parameter int WORDS_PER_LINE = 2,
    parameter int WORD_OFF_BITS  = $clog2(WORDS_PER_LINE),
    parameter int BYTE_OFF_BITS  = $clog2(BITS_PER_WORD / 8),
    parameter int LINE_ADDR_BITS = ADDR_BITS - WORD_OFF_BITS - BYTE_OFF_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     llc_mem_req_valid,
    output logic                     llc_mem_req_ready,
    llc_mem_req_t.in                 llc_mem_req_i,
    output logic                     llc_mem_rsp_valid,
    input  logic                     llc_mem_rsp_ready,
    llc_mem_rsp_t.out                llc_mem_rsp_o,
    output logic                     mem_req_valid,
    input  logic                     mem_req_ready,
    output logic                     mem_req_write,
    output logic [ADDR_BITS-1:0]     mem_req_addr,
    output logic [BITS_PER_WORD-1:0] mem_req_wdata,
    output logic [2:0]               mem_req_hsize,
    output logic [1:0]               mem_req_hprot,
    input  logic                     mem_rsp_valid,
    input  logic [BITS_PER_WORD-1:0] mem_rsp_data
);

    localparam int CNT_W = WORD_OFF_BITS + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RSP} state_t;

    state_t state, state_next;

    logic [LINE_ADDR_BITS-1:0]               addr_q;
    logic [WORDS_PER_LINE*BITS_PER_WORD-1:0] line_q;
    logic [CNT_W-1:0]                        issue_cnt;
    logic [CNT_W-1:0]                        rsp_cnt;
    logic [WORD_OFF_BITS-1:0]                issue_idx;
    logic [WORD_OFF_BITS-1:0]                rsp_idx;
    logic                                    req_fire;
    logic                                    beat_fire;
    logic                                    rsp_capture;
    logic                                    last_beat;
    logic                                    last_rsp;

    assign issue_idx          = issue_cnt[WORD_OFF_BITS-1:0];
    assign rsp_idx            = rsp_cnt[WORD_OFF_BITS-1:0];
    assign mem_req_addr       = {addr_q, issue_idx, {BYTE_OFF_BITS{1'b0}}};
    assign mem_req_wdata      = line_q[BITS_PER_WORD*int'(issue_idx) +: BITS_PER_WORD];
    assign llc_mem_rsp_o.line = line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        llc_mem_req_ready = (state == IDLE);
        llc_mem_rsp_valid = (state == RSP);
        req_fire          = llc_mem_req_valid && llc_mem_req_ready;
        beat_fire         = mem_req_valid && mem_req_ready;
        last_beat         = beat_fire && (issue_cnt == LAST);
        // Responses count only while collecting; anything else is dropped.
        rsp_capture       = (state == READ) && mem_rsp_valid && (rsp_cnt <= LAST);
        last_rsp          = rsp_capture && (rsp_cnt == LAST);
        case (state)
            IDLE:  if (req_fire) state_next = llc_mem_req_i.hwrite ? WRITE : READ;
            WRITE: if (last_beat) state_next = IDLE;
            READ:  if (last_rsp) state_next = RSP;
            RSP:   if (llc_mem_rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q        <= '0;
            line_q        <= '0;
            issue_cnt     <= '0;
            rsp_cnt       <= '0;
            mem_req_valid <= 1'b0;
            mem_req_write <= 1'b0;
            mem_req_hsize <= '0;
            mem_req_hprot <= '0;
        end else begin
            if (req_fire) begin
                addr_q        <= llc_mem_req_i.addr;
                line_q        <= llc_mem_req_i.line;
                mem_req_write <= llc_mem_req_i.hwrite;
                mem_req_hsize <= llc_mem_req_i.hsize;
                mem_req_hprot <= llc_mem_req_i.hprot;
                issue_cnt     <= '0;
                rsp_cnt       <= '0;
                mem_req_valid <= 1'b1;
            end
            if (beat_fire) begin
                issue_cnt <= issue_cnt + 1'b1;
                if (last_beat) mem_req_valid <= 1'b0;
            end
            // Read data overwrites the latched request line word by word.
            if (rsp_capture) begin
                line_q[BITS_PER_WORD*int'(rsp_idx) +: BITS_PER_WORD] <= mem_rsp_data;
                rsp_cnt <= rsp_cnt + 1'b1;
            end
            if (last_rsp) mem_req_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_llc_mem_bridge.sv
// Directed bench for llc_mem_bridge: scoreboarded memory beats and LLC lines,
// an in-order memory responder, and explicit checks on timing and reset.
module tb_llc_mem_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         llc_mem_req_valid;
    logic         llc_mem_req_ready;
    logic         llc_mem_rsp_valid;
    logic         llc_mem_rsp_ready;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_write;
    logic [31:0]  mem_req_addr;
    logic [63:0]  mem_req_wdata;
    logic [2:0]   mem_req_hsize;
    logic [1:0]   mem_req_hprot;
    logic         mem_rsp_valid;
    logic [63:0]  mem_rsp_data;

    logic         auto_valid;
    logic [63:0]  auto_data;
    logic         spur_valid;
    logic [63:0]  spur_data;
    logic         pend_valid;
    logic [63:0]  pend_data;

    assign mem_rsp_valid = auto_valid | spur_valid;
    assign mem_rsp_data  = spur_valid ? spur_data : auto_data;

    always #5 clk = ~clk;

    llc_mem_req_t #(.LINE_ADDR_BITS(28), .LINE_BITS(128)) req_if ();
    llc_mem_rsp_t #(.LINE_BITS(128)) rsp_if ();

    llc_mem_bridge #(
        .ADDR_BITS(32),
        .BITS_PER_WORD(64),
        .WORDS_PER_LINE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .llc_mem_req_valid(llc_mem_req_valid),
        .llc_mem_req_ready(llc_mem_req_ready),
        .llc_mem_req_i(req_if),
        .llc_mem_rsp_valid(llc_mem_rsp_valid),
        .llc_mem_rsp_ready(llc_mem_rsp_ready),
        .llc_mem_rsp_o(rsp_if),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_req_hsize(mem_req_hsize),
        .mem_req_hprot(mem_req_hprot),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data)
    );

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [2:0]  hsize;
        logic [1:0]  hprot;
    } beat_t;

    beat_t        exp_beats[$];
    logic [127:0] exp_lines[$];
    logic [63:0]  rd_q[$];
    int           checks   = 0;
    int           failures = 0;
    int           overlap  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: a read beat accepted at an edge returns its word in the next cycle.
    always @(negedge clk) begin
        auto_valid = pend_valid;
        auto_data  = pend_data;
        if (auto_valid && mem_req_valid && mem_req_ready) overlap++;
        pend_valid = 1'b0;
        if (!rst && mem_req_valid && mem_req_ready && !mem_req_write) begin
            pend_valid = 1'b1;
            pend_data  = (rd_q.size() != 0) ? rd_q.pop_front() : 64'h0;
        end
    end

    logic         beat_held = 1'b0;
    beat_t        held_beat;
    logic         rsp_held = 1'b0;
    logic [127:0] held_line;

    always @(negedge clk) begin
        if (rst) begin
            beat_held = 1'b0;
            rsp_held  = 1'b0;
        end else begin
            if (beat_held) begin
                chk("beat_hold_valid", mem_req_valid, 1'b1);
                chk("beat_hold_addr", mem_req_addr, held_beat.addr);
                chk("beat_hold_wdata", mem_req_wdata, held_beat.wdata);
                chk("beat_hold_write", mem_req_write, held_beat.write);
            end
            beat_held = mem_req_valid && !mem_req_ready;
            held_beat = '{mem_req_write, mem_req_addr, mem_req_wdata, mem_req_hsize, mem_req_hprot};
            if (mem_req_valid && mem_req_ready) begin
                if (exp_beats.size() == 0) begin
                    chk("beat_unexpected", mem_req_valid, 1'b0);
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    chk("beat_write", mem_req_write, b.write);
                    chk("beat_addr", mem_req_addr, b.addr);
                    if (b.write) chk("beat_wdata", mem_req_wdata, b.wdata);
                    chk("beat_hsize", mem_req_hsize, b.hsize);
                    chk("beat_hprot", mem_req_hprot, b.hprot);
                end
            end
            if (rsp_held) begin
                chk("rsp_hold_valid", llc_mem_rsp_valid, 1'b1);
                chk("rsp_hold_line", rsp_if.line, held_line);
            end
            rsp_held  = llc_mem_rsp_valid && !llc_mem_rsp_ready;
            held_line = rsp_if.line;
            if (llc_mem_rsp_valid) begin
                if (exp_lines.size() == 0) begin
                    chk("rsp_unexpected", llc_mem_rsp_valid, 1'b0);
                end else if (llc_mem_rsp_ready) begin
                    chk("rsp_line", rsp_if.line, exp_lines.pop_front());
                end
            end
        end
    end

    task automatic send_req(input logic w, input logic [2:0] hs, input logic [1:0] hp,
                            input logic [27:0] a, input logic [127:0] ln, output int waits);
        req_if.hwrite     = w;
        req_if.hsize      = hs;
        req_if.hprot      = hp;
        req_if.addr       = a;
        req_if.line       = ln;
        llc_mem_req_valid = 1'b1;
        waits = 0;
        while (!llc_mem_req_ready && waits < 50) begin
            tick();
            waits++;
        end
        chk("req_ready_seen", llc_mem_req_ready, 1'b1);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] ea;
            ea = {a, i[0], 3'b000};
            exp_beats.push_back('{w, ea, ln[i*64 +: 64], hs, hp});
        end
        tick();
        llc_mem_req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!llc_mem_rsp_valid && cycles < 50) begin
            tick();
            cycles++;
        end
        chk("wait_rsp_valid", llc_mem_rsp_valid, 1'b1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_beats.size() != 0 || exp_lines.size() != 0) && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_beats_left"}, exp_beats.size(), 0);
        chk({tag, "_lines_left"}, exp_lines.size(), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, llc_mem_rsp_valid, 1'b0);
        chk({tag, "_rsp_line"}, rsp_if.line, 128'h0);
        chk({tag, "_req_valid"}, mem_req_valid, 1'b0);
        chk({tag, "_write"}, mem_req_write, 1'b0);
        chk({tag, "_addr"}, mem_req_addr, 32'h0);
        chk({tag, "_wdata"}, mem_req_wdata, 64'h0);
        chk({tag, "_hsize"}, mem_req_hsize, 3'h0);
        chk({tag, "_hprot"}, mem_req_hprot, 2'h0);
        chk({tag, "_req_ready"}, llc_mem_req_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, w2, cyc;
        logic [127:0] l1, l3, l4, l5;

        rst = 1'b1;
        llc_mem_req_valid = 1'b0;
        llc_mem_rsp_ready = 1'b0;
        mem_req_ready = 1'b0;
        spur_valid = 1'b0;
        spur_data = '0;
        auto_valid = 1'b0;
        auto_data = '0;
        pend_valid = 1'b0;
        pend_data = '0;
        req_if.hwrite = 1'b0;
        req_if.hsize = '0;
        req_if.hprot = '0;
        req_if.addr = '0;
        req_if.line = '0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Read, zero wait: word-0 response coincides with beat-1 acceptance
        mem_req_ready = 1'b1;
        l1 = {64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
        rd_q.push_back(64'hAAAA_0000_0000_0001);
        rd_q.push_back(64'hBBBB_0000_0000_0002);
        exp_lines.push_back(l1);
        overlap = 0;
        send_req(1'b0, 3'd3, 2'd2, 28'h0000123, 128'h0, w);
        wait_rsp(cyc);
        chk("rd0_latency", cyc, 3);
        chk("rd0_overlap_seen", overlap > 0, 1'b1);
        tick();
        tick();
        chk("rd0_still_valid", llc_mem_rsp_valid, 1'b1);
        chk("rd0_line", rsp_if.line, l1);
        llc_mem_rsp_ready = 1'b1;
        tick();
        llc_mem_rsp_ready = 1'b0;
        chk("rd0_rsp_dropped", llc_mem_rsp_valid, 1'b0);
        chk("rd0_req_ready", llc_mem_req_ready, 1'b1);
        drain("rd0");

        // Write with 3 cycles of backpressure on beat 0
        mem_req_ready = 1'b0;
        send_req(1'b1, 3'd3, 2'd1, 28'h0000040, {64'h22, 64'h11}, w);
        for (int i = 0; i < 3; i++) begin
            chk("wr_stall_valid", mem_req_valid, 1'b1);
            chk("wr_stall_addr", mem_req_addr, 32'h400);
            chk("wr_stall_wdata", mem_req_wdata, 64'h11);
            chk("wr_stall_req_ready", llc_mem_req_ready, 1'b0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        chk("wr_beat1_addr", mem_req_addr, 32'h408);
        chk("wr_beat1_wdata", mem_req_wdata, 64'h22);
        chk("wr_busy", llc_mem_req_ready, 1'b0);
        tick();
        chk("wr_done_ready", llc_mem_req_ready, 1'b1);
        chk("wr_done_valid", mem_req_valid, 1'b0);
        chk("wr_no_rsp", llc_mem_rsp_valid, 1'b0);
        drain("wr");

        // Read held by LLC backpressure, spurious memory response during RSP
        l3 = {64'h3333_CCCC_0000_0002, 64'h3333_CCCC_0000_0001};
        rd_q.push_back(64'h3333_CCCC_0000_0001);
        rd_q.push_back(64'h3333_CCCC_0000_0002);
        exp_lines.push_back(l3);
        send_req(1'b0, 3'd2, 2'd3, 28'h0ABCDEF, '1, w);
        wait_rsp(cyc);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", llc_mem_rsp_valid, 1'b1);
            chk("bp_req_ready", llc_mem_req_ready, 1'b0);
            chk("bp_line", rsp_if.line, l3);
            spur_valid = (i == 1);
            spur_data  = 64'hDEAD_BEEF_DEAD_BEEF;
            tick();
        end
        spur_valid = 1'b0;
        llc_mem_rsp_ready = 1'b1;
        tick();
        llc_mem_rsp_ready = 1'b0;
        chk("bp_rsp_dropped", llc_mem_rsp_valid, 1'b0);
        drain("bp");

        // Reset mid-read after the first response has been captured
        rd_q.push_back(64'h4444_0000_0000_0001);
        rd_q.push_back(64'h4444_0000_0000_0002);
        send_req(1'b0, 3'd3, 2'd1, 28'h0000005, 128'h0, w);
        tick();
        mem_req_ready = 1'b0;
        tick();
        rst = 1'b1;
        exp_beats.delete();
        rd_q.delete();
        tick();
        chk_all_zero("midrst");
        rst = 1'b0;
        mem_req_ready = 1'b1;
        l4 = {64'h5555_0000_0000_0002, 64'h5555_0000_0000_0001};
        rd_q.push_back(64'h5555_0000_0000_0001);
        rd_q.push_back(64'h5555_0000_0000_0002);
        exp_lines.push_back(l4);
        send_req(1'b0, 3'd3, 2'd0, 28'h0000001, 128'h0, w);
        chk("after_rst_first_addr", mem_req_addr, 32'h10);
        llc_mem_rsp_ready = 1'b1;
        drain("after_rst");
        llc_mem_rsp_ready = 1'b0;

        // Back-to-back write then read
        l5 = {64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
        rd_q.push_back(64'h6666_0000_0000_0001);
        rd_q.push_back(64'h6666_0000_0000_0002);
        exp_lines.push_back(l5);
        llc_mem_rsp_ready = 1'b1;
        send_req(1'b1, 3'd3, 2'd3, 28'h0000200, {64'h44, 64'h33}, w);
        send_req(1'b0, 3'd2, 2'd0, 28'h0000201, 128'h0, w2);
        chk("b2b_read_wait", w2, 2);
        drain("b2b");
        llc_mem_rsp_ready = 1'b0;
        tick();
        chk("end_rd_q_empty", rd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
